// File: rtl/wrap_unit_counter_pkg.sv
// Shared definitions for the wrap-around field counter: screen and edit
// position codes, key polarity and the key auto-repeat FSM states.
package wrap_unit_counter_pkg;

    typedef enum logic [1:0] {
        SCR_TIME  = 2'd0,
        SCR_DATE  = 2'd1,
        SCR_ALARM = 2'd2,
        SCR_TZONE = 2'd3
    } screen_e;

    typedef enum logic [2:0] {
        POS_NONE  = 3'd0,
        POS_YEAR  = 3'd1,
        POS_MONTH = 3'd2,
        POS_DAY   = 3'd3,
        POS_HOUR  = 3'd4,
        POS_MIN   = 3'd5,
        POS_SEC   = 3'd6,
        POS_ZONE  = 3'd7
    } edit_pos_e;

    // Keys are active-low and already synchronised to clk.
    localparam logic KEY_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        KEY_IDLE,
        KEY_STEP,
        KEY_HOLD,
        KEY_REPEAT
    } key_state_e;

endpackage

// File: rtl/wrap_unit_counter_if.sv
// Control/status bundle of one field counter. The controller side (master)
// drives the requests and keys; the counter (slave) returns value and pulses.
interface wrap_unit_counter_if #(
    parameter int WIDTH = 7
);
    logic             tick;
    logic             edit_mode;
    logic [1:0]       screen;
    logic [2:0]       edit_pos;
    logic             key_plus_n;
    logic             key_minus_n;
    logic             over_plus;
    logic             over_minus;
    logic [WIDTH-1:0] lim_in;
    logic [WIDTH-1:0] value;
    logic             tick_out;
    logic             carry_plus;
    logic             carry_minus;

    modport master (
        output tick, edit_mode, screen, edit_pos, key_plus_n, key_minus_n,
               over_plus, over_minus, lim_in,
        input  value, tick_out, carry_plus, carry_minus
    );

    modport slave (
        input  tick, edit_mode, screen, edit_pos, key_plus_n, key_minus_n,
               over_plus, over_minus, lim_in,
        output value, tick_out, carry_plus, carry_minus
    );
endinterface

// File: rtl/wrap_unit_counter_key_repeater.sv
// Key auto-repeat: one step when the key goes down, then after a hold delay
// a step every REPEAT_CYCLES while the key stays down and the field selected.
//
// state      | meaning
// KEY_IDLE   | key released or field not selected; step issued on press
// KEY_STEP   | first step just issued, arm the hold delay
// KEY_HOLD   | waiting HOLD_CYCLES; step and move on at terminal count
// KEY_REPEAT | step at every terminal count, reload REPEAT_CYCLES-1
module wrap_unit_counter_key_repeater
    import wrap_unit_counter_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    input  logic sel_i,
    output logic step_o
);
    localparam int CW = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LOAD = CW'(REPEAT_CYCLES - 1);

    key_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pressed;

    assign pressed = (key_n_i == KEY_ACTIVE) && sel_i;

    // State and down-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= KEY_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter reload/decrement and the step pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_o  = 1'b0;
        if (!pressed) begin
            state_d = KEY_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                KEY_IDLE: begin
                    step_o  = 1'b1;
                    state_d = KEY_STEP;
                end
                KEY_STEP: begin
                    state_d = KEY_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
                KEY_HOLD: begin
                    if (cnt_q == '0) begin
                        step_o  = 1'b1;
                        state_d = KEY_REPEAT;
                        cnt_d   = REPEAT_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                KEY_REPEAT: begin
                    if (cnt_q == '0) begin
                        step_o = 1'b1;
                        cnt_d  = REPEAT_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = KEY_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end
endmodule

// File: rtl/wrap_unit_counter.sv
// Wrap-around calendar/time field counter with a dynamic upper limit.
// Run-mode ticks, time-zone carries and +/- keys (with auto-repeat) step the
// value; wraps produce one-cycle carry pulses for the next field up.
module wrap_unit_counter
    import wrap_unit_counter_pkg::*;
#(
    parameter int        WIDTH         = 7,
    parameter int        MIN_VAL       = 1,
    parameter int        MAX_VAL       = 12,
    parameter int        RESET_VAL     = 11,
    parameter screen_e   SCREEN_ID     = SCR_DATE,
    parameter edit_pos_e POS_ID        = POS_MONTH,
    parameter int        HOLD_CYCLES   = 50,
    parameter int        REPEAT_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    wrap_unit_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] value_q, value_d;
    logic             tick_out_q, tick_out_d;
    logic             carry_plus_q, carry_plus_d;
    logic             carry_minus_q, carry_minus_d;

    logic [WIDTH-1:0] eff_max, inc_v, dec_v;
    logic             inc_wrap, dec_wrap;
    logic             sel, minus_key_n;
    logic             step_plus, step_minus;

    // Out-of-range limits fall back to the static maximum.
    assign eff_max  = (bus.lim_in < MIN_V || bus.lim_in > MAX_V) ? MAX_V : bus.lim_in;
    assign inc_wrap = (value_q >= eff_max);
    assign dec_wrap = (value_q <= MIN_V);
    assign inc_v    = inc_wrap ? MIN_V : value_q + WIDTH'(1);
    assign dec_v    = dec_wrap ? eff_max : value_q - WIDTH'(1);

    assign sel = bus.edit_mode && (bus.screen == SCREEN_ID) && (bus.edit_pos == POS_ID);

    // With both keys down, + wins: the - repeater sees its key released.
    assign minus_key_n = (bus.key_plus_n == KEY_ACTIVE) ? ~KEY_ACTIVE : bus.key_minus_n;

    wrap_unit_counter_key_repeater #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_rep_plus (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (bus.key_plus_n),
        .sel_i   (sel),
        .step_o  (step_plus)
    );

    wrap_unit_counter_key_repeater #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_rep_minus (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (minus_key_n),
        .sel_i   (sel),
        .step_o  (step_minus)
    );

    // Priority mux: tick, time-zone carries, key steps, then run-mode clamp.
    always_comb begin
        value_d       = value_q;
        tick_out_d    = 1'b0;
        carry_plus_d  = 1'b0;
        carry_minus_d = 1'b0;
        if (bus.tick && !bus.edit_mode) begin
            value_d    = inc_v;
            tick_out_d = inc_wrap;
        end else if (bus.edit_mode && bus.over_plus && bus.over_minus) begin
            value_d = value_q;
        end else if (bus.edit_mode && bus.over_plus) begin
            value_d      = inc_v;
            carry_plus_d = inc_wrap;
        end else if (bus.edit_mode && bus.over_minus) begin
            value_d       = dec_v;
            carry_minus_d = dec_wrap;
        end else if (step_plus) begin
            value_d = inc_v;
        end else if (step_minus) begin
            value_d = dec_v;
        end else if (!bus.edit_mode && value_q > eff_max) begin
            value_d = eff_max;
        end
    end

    // Value and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q       <= RST_V;
            tick_out_q    <= 1'b0;
            carry_plus_q  <= 1'b0;
            carry_minus_q <= 1'b0;
        end else begin
            value_q       <= value_d;
            tick_out_q    <= tick_out_d;
            carry_plus_q  <= carry_plus_d;
            carry_minus_q <= carry_minus_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.tick_out    = tick_out_q;
    assign bus.carry_plus  = carry_plus_q;
    assign bus.carry_minus = carry_minus_q;
endmodule

// File: tb/tb_wrap_unit_counter.sv
// Bench for wrap_unit_counter: a month-style (1..12) and a day-style (1..31)
// instance share the same stimulus; a cycle-level reference model predicts
// both from the counting rules and key hold-time arithmetic.
module tb_wrap_unit_counter;
    import wrap_unit_counter_pkg::*;

    localparam int HOLD   = 4;
    localparam int REPEAT = 2;
    localparam int MAXV [2] = '{12, 31};
    localparam int RSTV [2] = '{11, 31};

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, edit_mode, key_plus_n, key_minus_n, over_plus, over_minus;
    logic [1:0] screen;
    logic [2:0] edit_pos;
    logic [6:0] lim_in;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_val [2];
    int exp_tick [2];
    int exp_cp [2];
    int exp_cm [2];
    int held_p = 0;
    int held_m = 0;

    always #5 clk = ~clk;

    wrap_unit_counter_if #(.WIDTH(7)) if_m ();
    wrap_unit_counter_if #(.WIDTH(7)) if_d ();

    assign if_m.tick = tick;          assign if_d.tick = tick;
    assign if_m.edit_mode = edit_mode; assign if_d.edit_mode = edit_mode;
    assign if_m.screen = screen;      assign if_d.screen = screen;
    assign if_m.edit_pos = edit_pos;  assign if_d.edit_pos = edit_pos;
    assign if_m.key_plus_n = key_plus_n;   assign if_d.key_plus_n = key_plus_n;
    assign if_m.key_minus_n = key_minus_n; assign if_d.key_minus_n = key_minus_n;
    assign if_m.over_plus = over_plus;     assign if_d.over_plus = over_plus;
    assign if_m.over_minus = over_minus;   assign if_d.over_minus = over_minus;
    assign if_m.lim_in = lim_in;      assign if_d.lim_in = lim_in;

    wrap_unit_counter #(
        .WIDTH(7), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(11),
        .SCREEN_ID(SCR_DATE), .POS_ID(POS_MONTH),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT)
    ) dut_m (
        .clk(clk), .reset(reset), .bus(if_m)
    );

    wrap_unit_counter #(
        .WIDTH(7), .MIN_VAL(1), .MAX_VAL(31), .RESET_VAL(31),
        .SCREEN_ID(SCR_DATE), .POS_ID(POS_MONTH),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT)
    ) dut_d (
        .clk(clk), .reset(reset), .bus(if_d)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // A key held for h consecutive selected cycles steps on the first cycle,
    // then after the STEP cycle plus HOLD cycles, then every REPEAT cycles.
    function automatic bit key_steps(input int h);
        if (h == 1) return 1'b1;
        if (h >= HOLD + 2 && ((h - HOLD - 2) % REPEAT) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit sel, sp, sm, wrap;
        int em;
        sel = edit_mode && (screen == 2'd1) && (edit_pos == 3'd2);
        if (reset) begin
            held_p = 0;
            held_m = 0;
        end else begin
            held_p = (!key_plus_n && sel) ? held_p + 1 : 0;
            held_m = (!key_minus_n && key_plus_n && sel) ? held_m + 1 : 0;
        end
        sp = key_steps(held_p);
        sm = key_steps(held_m);
        for (int d = 0; d < 2; d++) begin
            exp_tick[d] = 0;
            exp_cp[d]   = 0;
            exp_cm[d]   = 0;
            if (reset) begin
                exp_val[d] = RSTV[d];
            end else begin
                em = (int'(lim_in) < 1 || int'(lim_in) > MAXV[d]) ? MAXV[d] : int'(lim_in);
                if (tick && !edit_mode) begin
                    wrap = exp_val[d] >= em;
                    exp_tick[d] = wrap;
                    exp_val[d]  = wrap ? 1 : exp_val[d] + 1;
                end else if (edit_mode && over_plus && over_minus) begin
                    exp_val[d] = exp_val[d];
                end else if (edit_mode && over_plus) begin
                    wrap = exp_val[d] >= em;
                    exp_cp[d]  = wrap;
                    exp_val[d] = wrap ? 1 : exp_val[d] + 1;
                end else if (edit_mode && over_minus) begin
                    wrap = exp_val[d] <= 1;
                    exp_cm[d]  = wrap;
                    exp_val[d] = wrap ? em : exp_val[d] - 1;
                end else if (sp) begin
                    exp_val[d] = (exp_val[d] >= em) ? 1 : exp_val[d] + 1;
                end else if (sm) begin
                    exp_val[d] = (exp_val[d] <= 1) ? em : exp_val[d] - 1;
                end else if (!edit_mode && exp_val[d] > em) begin
                    exp_val[d] = em;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            check("val_m",   int'(if_m.value),       exp_val[0]);
            check("tick_m",  int'(if_m.tick_out),    exp_tick[0]);
            check("cplus_m", int'(if_m.carry_plus),  exp_cp[0]);
            check("cminus_m", int'(if_m.carry_minus), exp_cm[0]);
            check("val_d",   int'(if_d.value),       exp_val[1]);
            check("tick_d",  int'(if_d.tick_out),    exp_tick[1]);
            check("cplus_d", int'(if_d.carry_plus),  exp_cp[1]);
            check("cminus_d", int'(if_d.carry_minus), exp_cm[1]);
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b1; edit_mode = 1'b0; screen = 2'd1; edit_pos = 3'd2;
        key_plus_n = 1'b1; key_minus_n = 1'b1; over_plus = 1'b0; over_minus = 1'b0;
        lim_in = 7'd0;
        exp_val[0] = 0; exp_val[1] = 0;

        // Reset held with tick high.
        run(3);
        check("rst_val", int'(if_m.value), 11);
        reset = 1'b0; tick = 1'b0;
        run(1);

        // Run-mode wrap 12 -> 1 with a single-cycle tick_out.
        tick = 1'b1; run(2);
        check("wrap_val", int'(if_m.value), 1);
        check("wrap_tick", int'(if_m.tick_out), 1);
        tick = 1'b0; run(1);
        check("tick_drop", int'(if_m.tick_out), 0);
        tick = 1'b1; run(1);
        tick = 1'b0; run(1);

        // Edit mode: minus key single presses, underflow without carry.
        edit_mode = 1'b1;
        key_minus_n = 1'b0; run(1);
        key_minus_n = 1'b1; run(1);
        key_minus_n = 1'b0; run(1);
        key_minus_n = 1'b1; run(1);
        check("key_under", int'(if_m.value), 12);
        check("key_nocarry", int'(if_m.carry_minus), 0);

        // Time-zone carries, then both at once; tick in edit mode is dropped.
        over_plus = 1'b1; run(1);
        check("tz_plus_c", int'(if_m.carry_plus), 1);
        over_plus = 1'b0; over_minus = 1'b1; run(1);
        over_plus = 1'b1; run(1);
        over_plus = 1'b0; over_minus = 1'b0; tick = 1'b1; run(2);
        tick = 1'b0;
        over_plus = 1'b1; run(1);
        over_plus = 1'b0; run(1);

        // Auto-repeat from value 1: steps after 1, 6, 8, 10, 12 held cycles.
        key_plus_n = 1'b0; run(12);
        check("repeat_val", int'(if_m.value), 6);
        key_plus_n = 1'b1; run(3);
        edit_pos = 3'd3; key_plus_n = 1'b0; run(8);
        key_plus_n = 1'b1; edit_pos = 3'd2;
        key_plus_n = 1'b0; key_minus_n = 1'b0; run(8);
        key_plus_n = 1'b1; run(9);
        key_minus_n = 1'b1; run(1);

        // Day limits: clamp in run mode, wrap at dynamic limit.
        edit_mode = 1'b0; reset = 1'b1; run(1);
        reset = 1'b0; lim_in = 7'd31; run(1);
        lim_in = 7'd28; run(1);
        check("clamp_d", int'(if_d.value), 28);
        lim_in = 7'd0; run(2);
        lim_in = 7'd28; tick = 1'b1; run(1);
        check("lim_wrap_d", int'(if_d.value), 1);
        tick = 1'b0; run(2);

        // Randomised traffic with persistent keys and mode.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) edit_mode = ~edit_mode;
            tick       = ($urandom_range(0, 3) == 0);
            over_plus  = ($urandom_range(0, 11) == 0);
            over_minus = ($urandom_range(0, 11) == 0);
            screen   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            edit_pos = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            if ($urandom_range(0, 15) == 0) key_plus_n  = ~key_plus_n;
            if ($urandom_range(0, 15) == 0) key_minus_n = ~key_minus_n;
            if ($urandom_range(0, 30) == 0) lim_in = 7'($urandom_range(0, 40));
            reset = ($urandom_range(0, 299) == 0);
            run(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
